// File: rtl/alarm_tone_sequencer.sv
// Egg-timer alarm: cadenced beep/gap pattern with five tone modes, driving the
// mono amplifier PWM and shutdown pins directly.
module alarm_tone_sequencer #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SWEEP_W     = 5,
  parameter int unsigned SHIFT       = 6,
  parameter int unsigned STEP_CYCLES = 65536,
  parameter int unsigned BEEP_CYCLES = 2500000,
  parameter int unsigned GAP_CYCLES  = 1250000,
  parameter int unsigned REPEATS     = 8
) (
  input  logic             pulse_5MHz,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] base_div,
  output logic             AUD_PWM,
  output logic             AUD_SD,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PH_MAX = (BEEP_CYCLES > GAP_CYCLES) ? BEEP_CYCLES : GAP_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned B_W    = (REPEATS > 1) ? $clog2(REPEATS) : 1;
  localparam int unsigned OFS_W  = SWEEP_W + SHIFT;
  localparam int unsigned SUM_W  = ((DIV_W > OFS_W) ? DIV_W : OFS_W) + 1;

  typedef enum logic [1:0] {IDLE, BEEP, GAP} state_t;

  state_t             state;
  logic [PH_W-1:0]    ph;
  logic [STEP_W-1:0]  step;
  logic [SWEEP_W-1:0] s;
  logic               dir;
  logic [B_W-1:0]     b;
  logic [DIV_W-1:0]   tcnt;
  logic [2:0]         mode_q;
  logic [DIV_W-1:0]   base_q;

  // Half-period for a given mode/sweep position; saturates instead of wrapping
  function automatic logic [DIV_W-1:0] calc_h(input logic [2:0] md, input logic [DIV_W-1:0] base,
                                              input logic [SWEEP_W-1:0] sv, input logic dv,
                                              input logic odd);
    logic [SWEEP_W-1:0] o;
    logic [SUM_W-1:0]   sum;
    logic [DIV_W-1:0]   h;
    o = '0;
    case (md)
      3'd1:    o = sv;
      3'd2:    o = ~sv;
      3'd3:    o = dv ? ~sv : sv;
      3'd4:    o = odd ? '1 : '0;
      default: o = '0;
    endcase
    sum = SUM_W'(base) + (SUM_W'(o) << SHIFT);
    if (|(sum >> DIV_W)) h = '1;
    else                 h = sum[DIV_W-1:0];
    if (h == '0) h = DIV_W'(1);
    return h;
  endfunction

  logic [DIV_W-1:0] h_start, h_run, h_next;
  assign h_start = calc_h(mode, base_div, '0, 1'b0, 1'b0);
  assign h_run   = calc_h(mode_q, base_q, s, dir, b[0]);
  assign h_next  = calc_h(mode_q, base_q, s, dir, ~b[0]);

  always_ff @(posedge pulse_5MHz or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ph      <= '0;
      step    <= '0;
      s       <= '0;
      dir     <= 1'b0;
      b       <= '0;
      tcnt    <= '0;
      mode_q  <= '0;
      base_q  <= '0;
      AUD_PWM <= 1'b0;
      AUD_SD  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort wins over start and over a same-cycle natural completion
        state   <= IDLE;
        ph      <= '0;
        step    <= '0;
        s       <= '0;
        dir     <= 1'b0;
        b       <= '0;
        tcnt    <= '0;
        AUD_PWM <= 1'b0;
        AUD_SD  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= BEEP;
              mode_q  <= mode;
              base_q  <= base_div;
              ph      <= '0;
              step    <= '0;
              s       <= '0;
              dir     <= 1'b0;
              b       <= '0;
              tcnt    <= h_start - DIV_W'(1);
              AUD_PWM <= 1'b0;
              AUD_SD  <= 1'b1;
              busy    <= 1'b1;
            end
          end
          BEEP: begin
            if (ph == PH_W'(BEEP_CYCLES - 1)) begin
              state   <= GAP;
              ph      <= '0;
              AUD_PWM <= 1'b0;
            end else begin
              ph <= ph + PH_W'(1);
              if (tcnt == '0) begin
                AUD_PWM <= ~AUD_PWM;
                tcnt    <= h_run - DIV_W'(1);
              end else begin
                tcnt <= tcnt - DIV_W'(1);
              end
            end
            // Sweep index advances only while sounding; direction flips on wrap
            if (step == STEP_W'(STEP_CYCLES - 1)) begin
              step <= '0;
              s    <= s + SWEEP_W'(1);
              if (s == '1) dir <= ~dir;
            end else begin
              step <= step + STEP_W'(1);
            end
          end
          GAP: begin
            if (ph == PH_W'(GAP_CYCLES - 1)) begin
              ph <= '0;
              if (REPEATS != 0 && b == B_W'(REPEATS - 1)) begin
                state  <= IDLE;
                busy   <= 1'b0;
                AUD_SD <= 1'b0;
                done   <= 1'b1;
              end else begin
                state <= BEEP;
                b     <= b + B_W'(1);
                tcnt  <= h_next - DIV_W'(1);
              end
            end else begin
              ph <= ph + PH_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_tone_sequencer.sv
// Scoreboard bench for alarm_tone_sequencer: expected output events are queued
// per instance at stimulus time and matched by a negedge monitor.
module tb_alarm_tone_sequencer;

  localparam int K_PWM  = 0;
  localparam int K_DONE = 1;
  localparam int K_BUSY = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] start, stop;
  logic [2:0] mode;
  logic [7:0] base_div;
  logic [2:0] pwm, sd, busy, done;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int kind;
    int val;
    int t;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  ev_t q2[$];

  // ch0: main config, ch1: endless, ch2: long beep for saturation
  alarm_tone_sequencer #(.DIV_W(8), .SWEEP_W(2), .SHIFT(1), .STEP_CYCLES(8),
                         .BEEP_CYCLES(40), .GAP_CYCLES(20), .REPEATS(2)) u_dut (
    .pulse_5MHz(clk), .reset(reset), .start(start[0]), .stop(stop[0]), .mode(mode),
    .base_div(base_div), .AUD_PWM(pwm[0]), .AUD_SD(sd[0]), .busy(busy[0]), .done(done[0]));

  alarm_tone_sequencer #(.DIV_W(8), .SWEEP_W(2), .SHIFT(1), .STEP_CYCLES(8),
                         .BEEP_CYCLES(40), .GAP_CYCLES(20), .REPEATS(0)) u_dut_endless (
    .pulse_5MHz(clk), .reset(reset), .start(start[1]), .stop(stop[1]), .mode(mode),
    .base_div(base_div), .AUD_PWM(pwm[1]), .AUD_SD(sd[1]), .busy(busy[1]), .done(done[1]));

  alarm_tone_sequencer #(.DIV_W(8), .SWEEP_W(2), .SHIFT(1), .STEP_CYCLES(8),
                         .BEEP_CYCLES(600), .GAP_CYCLES(20), .REPEATS(1)) u_dut_sat (
    .pulse_5MHz(clk), .reset(reset), .start(start[2]), .stop(stop[2]), .mode(mode),
    .base_div(base_div), .AUD_PWM(pwm[2]), .AUD_SD(sd[2]), .busy(busy[2]), .done(done[2]));

  task automatic push_ev(input int ch, input int kind, input int val, input int t);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.t    = t;
    if (ch == 0)      q0.push_back(e);
    else if (ch == 1) q1.push_back(e);
    else              q2.push_back(e);
  endtask

  function automatic int q_size(input int ch);
    if (ch == 0) return q0.size();
    if (ch == 1) return q1.size();
    return q2.size();
  endfunction

  task automatic observe(input int ch, input int kind, input int val);
    ev_t e;
    bit  got;
    got = 1'b0;
    e.kind = -1; e.val = -1; e.t = -1;
    if (ch == 0 && q0.size() > 0)      begin e = q0.pop_front(); got = 1'b1; end
    else if (ch == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
    else if (ch == 2 && q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL unexpected_event ch%0d: kind=%0d val=%0d at t=%0d, none expected",
               ch, kind, val, cyc);
    end else if (e.kind != kind || e.val != val || e.t != cyc) begin
      errors++;
      $display("FAIL event ch%0d: got kind=%0d val=%0d t=%0d, expected kind=%0d val=%0d t=%0d",
               ch, kind, val, cyc, e.kind, e.val, e.t);
    end
  endtask

  // Monitor: report every output change as an event, in pwm/done/busy order
  logic [2:0] pwm_p = 3'b000;
  logic [2:0] busy_p = 3'b000;
  always @(negedge clk) begin
    for (int ch = 0; ch < 3; ch++) begin
      checks++;
      if (sd[ch] !== busy[ch]) begin
        errors++;
        $display("FAIL sd_mirror ch%0d t=%0d: AUD_SD=%b busy=%b", ch, cyc, sd[ch], busy[ch]);
      end
      if (pwm[ch] !== pwm_p[ch]) observe(ch, K_PWM, int'(pwm[ch]));
      if (done[ch] === 1'b1)     observe(ch, K_DONE, 1);
      if (busy[ch] !== busy_p[ch]) observe(ch, K_BUSY, int'(busy[ch]));
    end
    pwm_p  = pwm;
    busy_p = busy;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic expect_drained(input int ch, input string name);
    chk(name, q_size(ch), 0);
  endtask

  task automatic do_start(input int ch, input logic [2:0] m, input logic [7:0] bd, output int t0);
    @(negedge clk);
    mode     = m;
    base_div = bd;
    start[ch] = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start[ch] = 1'b0;
  endtask

  // Constant half-period h over a 40-cycle beep starting at edge tb
  task automatic push_beep(input int ch, input int tb, input int h);
    int v;
    v = 0;
    for (int m = 1; m * h < 40; m++) begin
      v = 1 - v;
      push_ev(ch, K_PWM, v, tb + m * h);
    end
    if (v == 1) push_ev(ch, K_PWM, 0, tb + 40);
  endtask

  task automatic push_end(input int ch, input int t);
    push_ev(ch, K_DONE, 1, t);
    push_ev(ch, K_BUSY, 0, t);
  endtask

  int t0;
  int sweep_up[12]  = '{4, 8, 12, 18, 26, 36, 66, 72, 80, 90, 94, 100};
  int sweep_tri[12] = '{4, 8, 12, 18, 26, 36, 68, 76, 82, 86, 90, 94};

  initial begin
    reset    = 1'b1;
    start    = 3'b000;
    stop     = 3'b000;
    mode     = 3'd0;
    base_div = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int ch = 0; ch < 3; ch++) begin
      chk($sformatf("reset_pwm_ch%0d", ch), int'(pwm[ch]), 0);
      chk($sformatf("reset_sd_ch%0d", ch), int'(sd[ch]), 0);
      chk($sformatf("reset_busy_ch%0d", ch), int'(busy[ch]), 0);
      chk($sformatf("reset_done_ch%0d", ch), int'(done[ch]), 0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Fixed tone, with an ignored restart mid-beep carrying different settings
    do_start(0, 3'd0, 8'd4, t0);
    push_ev(0, K_BUSY, 1, t0);
    push_beep(0, t0, 4);
    push_beep(0, t0 + 60, 4);
    push_end(0, t0 + 120);
    repeat (19) @(posedge clk);
    @(negedge clk);
    mode = 3'd4; base_div = 8'd9; start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (115) @(posedge clk);
    expect_drained(0, "fixed_tone_drained");
    chk("fixed_tone_idle", int'(busy[0]), 0);

    // Sweep up: s held across the gap
    do_start(0, 3'd1, 8'd4, t0);
    push_ev(0, K_BUSY, 1, t0);
    for (int i = 0; i < 12; i++) push_ev(0, K_PWM, (i % 2 == 0) ? 1 : 0, t0 + sweep_up[i]);
    push_end(0, t0 + 120);
    repeat (135) @(posedge clk);
    expect_drained(0, "sweep_up_drained");

    // Triangle ramp: direction flips at each wrap of s
    do_start(0, 3'd3, 8'd4, t0);
    push_ev(0, K_BUSY, 1, t0);
    for (int i = 0; i < 12; i++) push_ev(0, K_PWM, (i % 2 == 0) ? 1 : 0, t0 + sweep_tri[i]);
    push_end(0, t0 + 120);
    repeat (135) @(posedge clk);
    expect_drained(0, "triangle_drained");

    // Two-tone alternate: even beep h=4, odd beep h=4+(3<<1)=10
    do_start(0, 3'd4, 8'd4, t0);
    push_ev(0, K_BUSY, 1, t0);
    push_beep(0, t0, 4);
    push_beep(0, t0 + 60, 10);
    push_end(0, t0 + 120);
    repeat (135) @(posedge clk);
    expect_drained(0, "two_tone_drained");

    // base_div=0 behaves as h=1 (toggle every cycle)
    do_start(0, 3'd0, 8'd0, t0);
    push_ev(0, K_BUSY, 1, t0);
    push_beep(0, t0, 1);
    push_beep(0, t0 + 60, 1);
    push_end(0, t0 + 120);
    repeat (135) @(posedge clk);
    expect_drained(0, "h_zero_drained");

    // Stop mid-beep at edge t0+14, then start+stop together in idle
    do_start(0, 3'd0, 8'd4, t0);
    push_ev(0, K_BUSY, 1, t0);
    push_ev(0, K_PWM, 1, t0 + 4);
    push_ev(0, K_PWM, 0, t0 + 8);
    push_ev(0, K_PWM, 1, t0 + 12);
    push_ev(0, K_PWM, 0, t0 + 14);
    push_ev(0, K_BUSY, 0, t0 + 14);
    repeat (13) @(posedge clk);
    @(negedge clk);
    stop[0] = 1'b1;
    @(posedge clk);
    #1 stop[0] = 1'b0;
    chk("stop_busy", int'(busy[0]), 0);
    chk("stop_pwm", int'(pwm[0]), 0);
    chk("stop_sd", int'(sd[0]), 0);
    chk("stop_done", int'(done[0]), 0);
    @(negedge clk);
    start[0] = 1'b1; stop[0] = 1'b1;
    @(posedge clk);
    #1 begin start[0] = 1'b0; stop[0] = 1'b0; end
    repeat (10) @(posedge clk);
    #1 chk("start_stop_idle", int'(busy[0]), 0);
    expect_drained(0, "stop_drained");

    // Saturation: base 250, s=3 at each reload -> h=min(256,255)=255
    do_start(2, 3'd1, 8'd250, t0);
    push_ev(2, K_BUSY, 1, t0);
    push_ev(2, K_PWM, 1, t0 + 250);
    push_ev(2, K_PWM, 0, t0 + 505);
    push_end(2, t0 + 620);
    repeat (640) @(posedge clk);
    expect_drained(2, "saturate_drained");

    // Endless mode: five full beeps, no done, then async reset mid-beep 5
    do_start(1, 3'd0, 8'd4, t0);
    push_ev(1, K_BUSY, 1, t0);
    for (int j = 0; j < 5; j++) push_beep(1, t0 + 60 * j, 4);
    push_ev(1, K_PWM, 1, t0 + 304);
    push_ev(1, K_PWM, 0, t0 + 305);
    push_ev(1, K_BUSY, 0, t0 + 305);
    repeat (305) @(posedge clk);
    #2;
    chk("endless_still_busy", int'(busy[1]), 1);
    chk("endless_pwm_high", int'(pwm[1]), 1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_pwm", int'(pwm[1]), 0);
    chk("async_reset_sd", int'(sd[1]), 0);
    chk("async_reset_busy", int'(busy[1]), 0);
    chk("async_reset_done", int'(done[1]), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    for (int ch = 0; ch < 3; ch++) expect_drained(ch, $sformatf("final_drained_ch%0d", ch));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
